bk_sub_pipe: RTL and testbench
==============================

Name: bk_sub_pipe

Overview:
- Pipelined W-bit subtractor built on a Brent-Kung parallel-prefix carry network. It is the inverse-direction companion of the combinational Brent-Kung adder.
- It accepts the same interleaved operand bus format as the adder and computes minuend minus subtrahend with a borrow-out.
- It sits between a valid/ready operand producer and a result consumer, and registers the prefix tree across two stages for timing.

Parameters:
- W, 12, operand width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- in_pairs  input  2*W  interleaved operands: bit 2i = minuend A[i], bit 2i+1 = subtrahend B[i].
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result this cycle.
- diff  output  W  (A - B) mod 2^W.
- borrow  output  1  1 when A < B (unsigned).

Behaviour:
- Arithmetic: diff = A + ~B + 1. borrow = ~carry_out of that addition. Prefix uses generate g_i = A_i & ~B_i and propagate p_i = A_i ^ ~B_i, with carry-in 1.
- Stage 1 (S1) on accept: register g/p per bit and the Brent-Kung up-sweep (block group g/p at levels 1..ceil(log2 W)). Also register the p vector needed for the sum.
- Stage 2 (S2): register the down-sweep carries, diff, and borrow into the output registers. diff, borrow and out_valid are driven directly from flops.
- Latency: a beat accepted in cycle N presents out_valid = 1 in cycle N+2 if no stall occurs.
- Throughput: 1 beat/cycle with out_ready held high.
- Handshake:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready; no combinational path from in_valid to in_ready.
- Stall: while out_valid & ~out_ready, diff and borrow stay stable and S2 holds. S1 holds if it is occupied. At most 2 beats are in flight; no beat is dropped or duplicated.
- S1 loads only on in transfer. When S1 advances without a new input, s1_valid clears.
- Reset: takes effect in the same edge it is sampled.
  - Reset values: s1_valid = 0, out_valid = 0, diff = 0, borrow = 0. in_ready reads 1 in the first cycle after reset.
  - Reset mid-operation discards both in-flight beats with no partial output.
- Boundary cases:
  - A = B gives diff = 0, borrow = 0.
  - A = 0, B = 2^W-1 gives diff = 1, borrow = 1.
  - B = 0 gives diff = A, borrow = 0.
  - All-ones in_pairs gives diff = 0, borrow = 0.
- Prefix tree for non-power-of-two W: pad to the next power of two with p = 1, g = 0 internally. Padding has no effect on diff or borrow.

Optional Feature:
- Macro BK_SUB_SAT_EN.
- Defined: unsigned saturating subtract. When borrow = 1, diff is forced to 0 in the S2 register; the borrow output is still reported as 1.
- Undefined: diff is the wrapped modulo-2^W result and there is no extra logic.
- Latency and handshake are identical in both builds.

Test Plan:
- W=12: A=0x800, B=0x001, in_valid pulse, out_ready=1 -> two cycles later out_valid=1, diff=0x7FF, borrow=0.
- W=12: A=0x000, B=0x001 -> diff=0xFFF, borrow=1; with BK_SUB_SAT_EN defined -> diff=0x000, borrow=1.
- Back-to-back stream of 16 random beats, out_ready=1 -> 16 results on consecutive cycles starting 2 cycles after the first, each matching a reference model; in_ready constantly 1.
- Backpressure: send 3 beats, hold out_ready=0 -> in_ready drops after the 2nd accept; out_valid/diff stable for 5 cycles; release -> results emitted in order, none lost.
- Reset with 2 beats in flight -> next cycle out_valid=0, diff=0, borrow=0, in_ready=1; the next new beat produces a correct result with latency 2.
- Edge operands A=B=0xABC, A=0xFFF B=0x000, A=0x000 B=0xFFF -> (0x000,0), (0xFFF,0), (0x001,1).

Source files
------------

// File: rtl/bk_sub_pipe.sv
// bk_sub_pipe: two-stage pipelined W-bit subtractor (A - B) built on a
// Brent-Kung parallel-prefix carry network with valid/ready handshakes.
// Operands arrive interleaved: in_pairs[2i] = A[i], in_pairs[2i+1] = B[i].
// Optional macro BK_SUB_SAT_EN: saturate diff to zero whenever borrow is set.
module bk_sub_pipe #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_pairs,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   diff,
  output logic           borrow
);

  localparam int LG = $clog2(W);
  localparam int N  = 1 << LG;

  logic           s1_valid;
  logic           s1_adv;
  logic           s2_adv;
  logic           in_fire;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [N-1:0]   g_pad;
  logic [N-1:0]   p_pad;
  logic [N-1:0]   ug [0:LG];
  logic [N-1:0]   up [0:LG];
  logic [N-1:0]   s1_g;
  logic [N-1:0]   s1_pg;
  logic [W-1:0]   s1_p;
  logic [N-1:0]   dg [0:LG];
  logic [W-1:0]   carry;
  logic [W-1:0]   diff_n;
  logic           borrow_n;

  // Pipeline advance: S2 frees when empty or drained, S1 when empty or S2 frees.
  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid & s1_adv;

  // De-interleave the operand bus.
  for (genvar i = 0; i < W; i++) begin : g_split
    assign a[i] = in_pairs[2*i];
    assign b[i] = in_pairs[2*i+1];
  end

  // Per-bit generate/propagate of A + ~B; carry-in of 1 folded into bit 0,
  // padding bits propagate without generating so they never disturb the result.
  always_comb begin
    g_pad        = '0;
    p_pad        = '1;
    g_pad[W-1:0] = a & ~b;
    g_pad[0]     = a[0] | ~b[0];
    p_pad[W-1:0] = ~(a ^ b);
  end

  assign ug[0] = g_pad;
  assign up[0] = p_pad;

  // Up-sweep: node i at level l covers the 2^l bits ending at i.
  for (genvar l = 1; l <= LG; l++) begin : g_up
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i + 1) % (2 ** l)) == 0) begin : g_node
        assign ug[l][i] = ug[l-1][i] | (up[l-1][i] & ug[l-1][i - 2 ** (l-1)]);
        assign up[l][i] = up[l-1][i] & up[l-1][i - 2 ** (l-1)];
      end else begin : g_pass
        assign ug[l][i] = ug[l-1][i];
        assign up[l][i] = up[l-1][i];
      end
    end
  end

  // Stage 1: capture up-sweep groups and raw propagate on an input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_pg    <= '0;
      s1_p     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_g  <= ug[LG];
        s1_pg <= up[LG];
        s1_p  <= p_pad[W-1:0];
      end
    end
  end

  assign dg[LG] = s1_g;

  // Down-sweep: fill the mid-block nodes so every index holds prefix 0..i.
  for (genvar l = LG - 1; l >= 0; l--) begin : g_dn
    if (l == 0) begin : g_last
      assign dg[0] = dg[1];
    end else begin : g_lvl
      for (genvar i = 0; i < N; i++) begin : g_bit
        if ((((i + 1) % (2 ** l)) == (2 ** (l-1))) && (i >= (2 ** l))) begin : g_node
          assign dg[l][i] = dg[l+1][i] | (s1_pg[i] & dg[l+1][i - 2 ** (l-1)]);
        end else begin : g_pass
          assign dg[l][i] = dg[l+1][i];
        end
      end
    end
  end

  assign carry[0] = 1'b1;
  for (genvar i = 1; i < W; i++) begin : g_carry
    assign carry[i] = dg[0][i-1];
  end

  // Sum bits and borrow (inverted carry-out), with optional saturation.
  always_comb begin
    borrow_n = ~dg[0][W-1];
    diff_n   = s1_p ^ carry;
`ifdef BK_SUB_SAT_EN
    if (borrow_n) begin
      diff_n = '0;
    end else begin
      diff_n = s1_p ^ carry;
    end
`else
    diff_n = s1_p ^ carry;
`endif
  end

  // Stage 2: output registers; hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        diff   <= diff_n;
        borrow <= borrow_n;
      end
    end
  end

endmodule

// File: tb/tb_bk_sub_pipe.sv
// tb_bk_sub_pipe: scoreboard bench for bk_sub_pipe (W=12). Expected results
// come from plain unsigned arithmetic and are queued at input acceptance; a
// monitor pops and compares on every output transfer.
module tb_bk_sub_pipe;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_pairs;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   diff;
  logic           borrow;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_lat = 1'b0;
  bit   chk_rdy = 1'b0;
  bit   rnd_done = 1'b0;

  bk_sub_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pairs  (in_pairs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    m.d   = a - b;
    m.b   = (a < b);
    m.acc = 0;
`ifdef BK_SUB_SAT_EN
    if (m.b) m.d = '0;
`endif
    return m;
  endfunction

  function automatic logic [2*W-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    for (int i = 0; i < W; i++) begin
      p[2*i]   = a[i];
      p[2*i+1] = b[i];
    end
    return p;
  endfunction

  // Present one beat, wait (bounded) for acceptance, then queue its expectation.
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    bit ok;
    int k;
    ok = 1'b0;
    k  = 0;
    in_pairs = pack(a, b);
    in_valid = 1'b1;
    while (!ok && k < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      k++;
      if (ok) begin
        e.acc = cyc;
        sb.push_back(e);
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    send_beat(a, b, model(a, b));
  endtask

  task automatic send_k(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] d, input logic br);
    exp_t e;
    e.d = d;
    e.b = br;
    e.acc = 0;
    send_beat(a, b, e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    chk("drain_pending", sb.size(), 64'd0);
    #1;
  endtask

  // Monitor: compare every output transfer against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_rdy) chk("in_ready_stream", in_ready, 64'd1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got diff=%0h borrow=%0b, expected no beat", diff, borrow);
        end else begin
          mon_e = sb.pop_front();
          chk("diff", diff, mon_e.d);
          chk("borrow", borrow, mon_e.b);
          if (chk_lat) chk("latency", cyc, mon_e.acc + 2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pairs  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_borrow", borrow, 64'd0);
    chk("rst_in_ready", in_ready, 64'd1);
    @(posedge clk);
    #1;

    // Single beat, explicit latency and value.
    chk_lat = 1'b1;
    send_k(12'h800, 12'h001, 12'h7FF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 64'd1);
    chk("t1_diff", diff, 64'h7FF);
    drain();

    // Underflow and edge operands.
`ifdef BK_SUB_SAT_EN
    send_k(12'h000, 12'h001, 12'h000, 1'b1);
    send_k(12'h000, 12'hFFF, 12'h000, 1'b1);
`else
    send_k(12'h000, 12'h001, 12'hFFF, 1'b1);
    send_k(12'h000, 12'hFFF, 12'h001, 1'b1);
`endif
    send_k(12'hABC, 12'hABC, 12'h000, 1'b0);
    send_k(12'hFFF, 12'h000, 12'hFFF, 1'b0);
    send_k(12'hFFF, 12'hFFF, 12'h000, 1'b0);
    send_k(12'h5A3, 12'h000, 12'h5A3, 1'b0);
    drain();

    // Back-to-back stream of 16 random beats.
    chk_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    end
    drain();
    chk_rdy = 1'b0;

    // Backpressure: two beats fill the pipe, third waits.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    send(12'h123, 12'h456);
    send(12'h900, 12'h0FF);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 64'd0);
    fork
      send(12'h777, 12'h111);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_out_valid", out_valid, 64'd1);
          chk("bp_diff_stable", diff, sb[0].d);
          chk("bp_borrow_stable", borrow, sb[0].b);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(12'h321, 12'h123);
    send(12'h010, 12'h020);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 64'd0);
    chk("mid_rst_diff", diff, 64'd0);
    chk("mid_rst_borrow", borrow, 64'd0);
    chk("mid_rst_in_ready", in_ready, 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    chk_lat = 1'b1;
    send(12'hC00, 12'h3FF);
    drain();

    // Random stream under random backpressure.
    chk_lat  = 1'b0;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
